noc_mesh_router: RTL and testbench

// - Parametrised 5-port (N,S,E,W,L) wormhole-free mesh router; every flit is a complete packet.
// - Routing is dimension-ordered XY. Flow control is credit-based. Each input has a FIFO.

---
 rtl/noc_mesh_router.sv | 168 ++++++++++++++++
 tb/tb_noc_mesh_router.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mesh_router.sv
// noc_mesh_router: 5-port XY mesh router with input FIFOs, round-robin output arbiters, credit flow control.
// Optional per-output forwarded-flit counters (stat_flits) when NOC_ROUTER_STATS_EN is defined.
module noc_mesh_router #(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int DATA_W     = 16,
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  parameter logic [4:0] PORT_MASK = 5'b11111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]        in_valid,
  output logic [4:0]        in_credit_o,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]        out_valid,
  input  logic [4:0]        out_credit_i,
  output logic              err_o
`ifdef NOC_ROUTER_STATS_EN
  ,output logic [5*16-1:0]  stat_flits
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [COORD_W-1:0] LX = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] LY = COORD_W'(YCOORD);

  logic [DATA_W-1:0] r_mem [5][FIFO_DEPTH];
  logic [AW-1:0]     r_wp [5];
  logic [AW-1:0]     r_rp [5];
  logic [NW-1:0]     r_cnt [5];
  logic [CW-1:0]     r_cred [5];
  logic [2:0]        r_ptr [5];

  logic [DATA_W-1:0] w_head [5];
  logic [4:0]        w_route [5];
  logic [2:0]        w_gidx [5];
  logic [4:0] w_nempty, w_full, w_mis, w_won, w_pop;
  logic [4:0] w_push, w_ovf, w_gnt, w_cin;
  logic [3:0] w_sum;
  logic [2:0] w_cand;

  assign w_cin = out_credit_i & PORT_MASK;

  // Route every FIFO head, then a round-robin search per output.
  always_comb begin
    w_nempty = '0;
    w_full   = '0;
    w_mis    = '0;
    w_won    = '0;
    w_gnt    = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = 0; i < 5; i++) begin
      w_head[i]  = r_mem[i][r_rp[i]];
      w_gidx[i]  = '0;
      w_route[i] = 5'b10000;
      if (w_head[i][2*COORD_W-1:COORD_W] > LX)
        w_route[i] = 5'b00100;
      else if (w_head[i][2*COORD_W-1:COORD_W] < LX)
        w_route[i] = 5'b01000;
      else if (w_head[i][COORD_W-1:0] > LY)
        w_route[i] = 5'b00001;
      else if (w_head[i][COORD_W-1:0] < LY)
        w_route[i] = 5'b00010;
      w_nempty[i] = (r_cnt[i] != '0);
      w_full[i]   = (r_cnt[i] == FULL);
      w_mis[i]    = w_nempty[i] && ((w_route[i] & PORT_MASK) == '0);
    end
    for (int o = 0; o < 5; o++) begin
      if (PORT_MASK[o] && r_cred[o] != '0) begin
        for (int k = 0; k < 5; k++) begin
          w_sum  = {1'b0, r_ptr[o]} + 4'(k);
          w_cand = (w_sum > 4'd4) ? 3'(w_sum - 4'd5) : w_sum[2:0];
          if (!w_gnt[o] && w_nempty[w_cand] && w_route[w_cand][o]) begin
            w_gnt[o]  = 1'b1;
            w_gidx[o] = w_cand;
          end
        end
      end
      if (w_gnt[o])
        w_won[w_gidx[o]] = 1'b1;
    end
  end

  assign w_pop  = w_won | w_mis;
  assign w_push = in_valid & PORT_MASK & (~w_full | w_pop);
  assign w_ovf  = in_valid & PORT_MASK & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (w_push[i])
        r_mem[i][r_wp[i]] <= in_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_wp[i]   <= '0;
        r_rp[i]   <= '0;
        r_cnt[i]  <= '0;
        r_cred[i] <= CMAX;
        r_ptr[i]  <= '0;
      end
      out_valid   <= '0;
      out_data    <= '0;
      in_credit_o <= '0;
      err_o       <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_push[i])
          r_wp[i] <= r_wp[i] + 1'b1;
        if (w_pop[i])
          r_rp[i] <= r_rp[i] + 1'b1;
        if (w_push[i] && !w_pop[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      for (int o = 0; o < 5; o++) begin
        out_valid[o] <= w_gnt[o];
        if (w_gnt[o]) begin
          out_data[o*DATA_W +: DATA_W] <= w_head[w_gidx[o]];
          r_ptr[o] <= (w_gidx[o] == 3'd4) ? 3'd0 : w_gidx[o] + 3'd1;
        end
        if (w_gnt[o] && !w_cin[o])
          r_cred[o] <= r_cred[o] - 1'b1;
        else if (!w_gnt[o] && w_cin[o]) begin
          if (r_cred[o] == CMAX)
            err_o <= 1'b1;
          else
            r_cred[o] <= r_cred[o] + 1'b1;
        end
      end
      in_credit_o <= w_pop & PORT_MASK;
      if (|w_mis || |w_ovf)
        err_o <= 1'b1;
    end
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] r_stat [5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < 5; o++)
        r_stat[o] <= '0;
    end else begin
      for (int o = 0; o < 5; o++)
        if (w_gnt[o])
          r_stat[o] <= r_stat[o] + 16'd1;
    end
  end

  always_comb begin
    stat_flits = '0;
    for (int o = 0; o < 5; o++)
      stat_flits[o*16 +: 16] = r_stat[o];
  end
`endif

endmodule

// File: tb/tb_noc_mesh_router.sv
// Directed testbench for noc_mesh_router: four tiles covering interior,
// XY hand-off, reduced credits and a wedge mask.
module tb_noc_mesh_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] ind  [4];
  logic [4:0]  inv  [4];
  logic [4:0]  ocr  [4];
  logic [79:0] outd [4];
  logic [4:0]  ov   [4];
  logic [4:0]  icr  [4];
  logic        err  [4];
`ifdef NOC_ROUTER_STATS_EN
  logic [79:0] st   [4];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_mesh_router #(.XCOORD(1), .YCOORD(1)) u_a (
    .clk(clk), .rst(rst), .in_data(ind[0]), .in_valid(inv[0]),
    .in_credit_o(icr[0]), .out_data(outd[0]), .out_valid(ov[0]),
    .out_credit_i(ocr[0]), .err_o(err[0])
`ifdef NOC_ROUTER_STATS_EN
    ,.stat_flits(st[0])
`endif
  );

  noc_mesh_router #(.XCOORD(2), .YCOORD(1)) u_b (
    .clk(clk), .rst(rst), .in_data(ind[1]), .in_valid(inv[1]),
    .in_credit_o(icr[1]), .out_data(outd[1]), .out_valid(ov[1]),
    .out_credit_i(ocr[1]), .err_o(err[1])
`ifdef NOC_ROUTER_STATS_EN
    ,.stat_flits(st[1])
`endif
  );

  noc_mesh_router #(.XCOORD(1), .YCOORD(1), .CREDITS(2)) u_c (
    .clk(clk), .rst(rst), .in_data(ind[2]), .in_valid(inv[2]),
    .in_credit_o(icr[2]), .out_data(outd[2]), .out_valid(ov[2]),
    .out_credit_i(ocr[2]), .err_o(err[2])
`ifdef NOC_ROUTER_STATS_EN
    ,.stat_flits(st[2])
`endif
  );

  noc_mesh_router #(.XCOORD(1), .YCOORD(1), .PORT_MASK(5'b10111)) u_d (
    .clk(clk), .rst(rst), .in_data(ind[3]), .in_valid(inv[3]),
    .in_credit_o(icr[3]), .out_data(outd[3]), .out_valid(ov[3]),
    .out_credit_i(ocr[3]), .err_o(err[3])
`ifdef NOC_ROUTER_STATS_EN
    ,.stat_flits(st[3])
`endif
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic clr_in;
    for (int n = 0; n < 4; n++) begin
      ind[n] = '0;
      inv[n] = '0;
      ocr[n] = '0;
    end
  endtask

  task automatic do_reset;
    clr_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      total++;
      if (ov[n] !== 5'b0) begin
        bad++;
        $display("FAIL reset_ov inst%0d got %b want 00000", n, ov[n]);
      end
      total++;
      if (icr[n] !== 5'b0) begin
        bad++;
        $display("FAIL reset_icr inst%0d got %b want 00000", n, icr[n]);
      end
      total++;
      if (err[n] !== 1'b0) begin
        bad++;
        $display("FAIL reset_err inst%0d got %b want 0", n, err[n]);
      end
      total++;
      if (outd[n] !== 80'h0) begin
        bad++;
        $display("FAIL reset_data inst%0d got %h want 0", n, outd[n]);
      end
    end
  endtask

  task automatic test_loopback;
    do_reset();
    ind[0][64 +: 16] = 16'h0011;
    inv[0] = 5'b10000;
    step();
    inv[0] = '0;
    total++;
    if (ov[0] !== 5'b0) begin
      bad++;
      $display("FAIL loop_early got %b want 00000", ov[0]);
    end
    step();
    total++;
    if (ov[0] !== 5'b10000) begin
      bad++;
      $display("FAIL loop_valid got %b want 10000", ov[0]);
    end
    total++;
    if (outd[0][64 +: 16] !== 16'h0011) begin
      bad++;
      $display("FAIL loop_data got %h want 0011", outd[0][64 +: 16]);
    end
    total++;
    if (icr[0] !== 5'b10000) begin
      bad++;
      $display("FAIL loop_credit got %b want 10000", icr[0]);
    end
    step();
    total++;
    if (ov[0] !== 5'b0 || icr[0] !== 5'b0) begin
      bad++;
      $display("FAIL loop_once got ov=%b icr=%b want 0/0", ov[0], icr[0]);
    end
    total++;
    if (outd[0][64 +: 16] !== 16'h0011) begin
      bad++;
      $display("FAIL loop_hold got %h want 0011", outd[0][64 +: 16]);
    end
  endtask

  task automatic test_xy;
    do_reset();
    ind[0][64 +: 16] = 16'h0023;
    ind[1][64 +: 16] = 16'h0023;
    inv[0] = 5'b10000;
    inv[1] = 5'b10000;
    step();
    inv[0] = '0;
    inv[1] = '0;
    step();
    total++;
    if (ov[0] !== 5'b00100 || outd[0][32 +: 16] !== 16'h0023) begin
      bad++;
      $display("FAIL xy_tile11 got ov=%b d=%h want 00100/0023",
               ov[0], outd[0][32 +: 16]);
    end
    total++;
    if (ov[1] !== 5'b00001 || outd[1][0 +: 16] !== 16'h0023) begin
      bad++;
      $display("FAIL xy_tile21 got ov=%b d=%h want 00001/0023",
               ov[1], outd[1][0 +: 16]);
    end
  endtask

  task automatic test_contention;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0A20;
    exp_d[1] = 16'h0B20;
    exp_d[2] = 16'h0C20;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      ind[0][0 +: 16]  = 16'h0A20;
      ind[0][16 +: 16] = 16'h0B20;
      ind[0][64 +: 16] = 16'h0C20;
      inv[0] = 5'b10011;
      step();
      inv[0] = '0;
      for (int k = 0; k < 3; k++) begin
        step();
        total++;
        if (ov[0] !== 5'b00100 || outd[0][32 +: 16] !== exp_d[k]) begin
          bad++;
          $display("FAIL contend r%0d k%0d got ov=%b d=%h want 00100/%h",
                   r, k, ov[0], outd[0][32 +: 16], exp_d[k]);
        end
      end
      step();
      total++;
      if (ov[0] !== 5'b0) begin
        bad++;
        $display("FAIL contend_end r%0d got %b want 00000", r, ov[0]);
      end
      ocr[0] = 5'b00100;
      repeat (3) step();
      ocr[0] = '0;
      step();
    end
    total++;
    if (err[0] !== 1'b0) begin
      bad++;
      $display("FAIL contend_err got %b want 0", err[0]);
    end
  endtask

  task automatic test_credit_stall;
    logic [15:0] got [2];
    int cnt;
    got[0] = 16'hFFFF;
    got[1] = 16'hFFFF;
    cnt = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ind[2][64 +: 16] = 16'h0020 | (16'(c) << 8);
      inv[2] = (c < 4) ? 5'b10000 : 5'b0;
      step();
      if (ov[2][2]) begin
        if (cnt < 2) got[cnt] = outd[2][32 +: 16];
        cnt++;
      end
    end
    inv[2] = '0;
    total++;
    if (cnt !== 2) begin
      bad++;
      $display("FAIL stall_count got %0d want 2", cnt);
    end
    total++;
    if (got[0] !== 16'h0020 || got[1] !== 16'h0120) begin
      bad++;
      $display("FAIL stall_data got %h,%h want 0020,0120", got[0], got[1]);
    end
    ocr[2] = 5'b00100;
    step();
    ocr[2] = '0;
    total++;
    if (ov[2] !== 5'b0) begin
      bad++;
      $display("FAIL stall_early got %b want 00000", ov[2]);
    end
    step();
    total++;
    if (ov[2] !== 5'b00100 || outd[2][32 +: 16] !== 16'h0220) begin
      bad++;
      $display("FAIL stall_resume got ov=%b d=%h want 00100/0220",
               ov[2], outd[2][32 +: 16]);
    end
    step();
    total++;
    if (ov[2] !== 5'b0) begin
      bad++;
      $display("FAIL stall_single got %b want 00000", ov[2]);
    end
    total++;
    if (err[2] !== 1'b0) begin
      bad++;
      $display("FAIL stall_err got %b want 0", err[2]);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] d [4];
    int n1;
    int n2;
    n1 = 0;
    n2 = 0;
    for (int k = 0; k < 4; k++) d[k] = 16'hFFFF;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      ind[2][64 +: 16] = 16'h0020 | (16'(c) << 8);
      inv[2] = 5'b10000;
      step();
      if (ov[2][2]) n1++;
    end
    inv[2] = '0;
    total++;
    if (n1 !== 2) begin
      bad++;
      $display("FAIL ovf_sent got %0d want 2", n1);
    end
    total++;
    if (err[2] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_err got %b want 1", err[2]);
    end
    for (int c = 0; c < 10; c++) begin
      ocr[2] = (c < 6) ? 5'b00100 : 5'b0;
      step();
      if (ov[2][2]) begin
        if (n2 < 4) d[n2] = outd[2][32 +: 16];
        n2++;
      end
    end
    total++;
    if (n2 !== 4) begin
      bad++;
      $display("FAIL ovf_kept got %0d want 4", n2);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (d[k] !== (16'h0220 + (16'(k) << 8))) begin
        bad++;
        $display("FAIL ovf_data%0d got %h want %h", k, d[k],
                 16'h0220 + (16'(k) << 8));
      end
    end
  endtask

  task automatic test_credit_sat;
    do_reset();
    ocr[0] = 5'b00100;
    step();
    ocr[0] = '0;
    total++;
    if (err[0] !== 1'b1) begin
      bad++;
      $display("FAIL credit_sat_err got %b want 1", err[0]);
    end
  endtask

  task automatic test_wedge;
    do_reset();
    ind[3][64 +: 16] = 16'h0001;
    ind[3][48 +: 16] = 16'h0011;
    inv[3] = 5'b11000;
    step();
    inv[3] = '0;
    total++;
    if (err[3] !== 1'b0 || ov[3] !== 5'b0) begin
      bad++;
      $display("FAIL wedge_c1 got err=%b ov=%b want 0/00000", err[3], ov[3]);
    end
    step();
    total++;
    if (err[3] !== 1'b1) begin
      bad++;
      $display("FAIL wedge_err got %b want 1", err[3]);
    end
    total++;
    if (icr[3] !== 5'b10000) begin
      bad++;
      $display("FAIL wedge_credit got %b want 10000", icr[3]);
    end
    total++;
    if (ov[3] !== 5'b0) begin
      bad++;
      $display("FAIL wedge_ov got %b want 00000", ov[3]);
    end
    step();
    total++;
    if (icr[3] !== 5'b0 || ov[3] !== 5'b0) begin
      bad++;
      $display("FAIL wedge_after got icr=%b ov=%b want 0/0", icr[3], ov[3]);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    ind[0][0 +: 16]  = 16'h0A20;
    ind[0][16 +: 16] = 16'h0B20;
    ind[0][64 +: 16] = 16'h0C20;
    inv[0] = 5'b10011;
    step();
    inv[0] = '0;
    step();
    total++;
    if (ov[0] !== 5'b00100) begin
      bad++;
      $display("FAIL rmid_pre got %b want 00100", ov[0]);
    end
    rst = 1'b1;
    #1;
    total++;
    if (ov[0] !== 5'b0 || outd[0] !== 80'h0) begin
      bad++;
      $display("FAIL rmid_async got ov=%b d=%h want 0/0", ov[0], outd[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (ov[0] !== 5'b0) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL rmid_flush got %0d valid cycles want 0", n);
    end
    ind[0][0 +: 16]  = 16'h1020;
    ind[0][16 +: 16] = 16'h1120;
    ind[0][48 +: 16] = 16'h1320;
    ind[0][64 +: 16] = 16'h1420;
    inv[0] = 5'b11011;
    step();
    inv[0] = '0;
    n = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (ov[0][2]) n++;
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL rmid_credits got %0d flits want 4", n);
    end
    total++;
    if (err[0] !== 1'b0) begin
      bad++;
      $display("FAIL rmid_err got %b want 0", err[0]);
    end
  endtask

`ifdef NOC_ROUTER_STATS_EN
  task automatic test_stats;
    do_reset();
    ind[0][0 +: 16]  = 16'h0011;
    ind[0][16 +: 16] = 16'h0011;
    ind[0][32 +: 16] = 16'h0011;
    inv[0] = 5'b00111;
    step();
    inv[0] = '0;
    repeat (6) step();
    total++;
    if (st[0][64 +: 16] !== 16'd3) begin
      bad++;
      $display("FAIL stats_local got %0d want 3", st[0][64 +: 16]);
    end
    total++;
    if (st[0][0 +: 64] !== 64'h0) begin
      bad++;
      $display("FAIL stats_other got %h want 0", st[0][0 +: 64]);
    end
  endtask
`endif

  initial begin
    clr_in();
    rst = 1'b1;
    test_reset();
    test_loopback();
    test_xy();
    test_contention();
    test_credit_stall();
    test_overflow();
    test_credit_sat();
    test_wedge();
    test_reset_mid();
`ifdef NOC_ROUTER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
